// File: rtl/dram_cmd_issue_queue.sv
// dram_cmd_issue_queue: in-order DRAM command FIFO with per-bank gated issue and read-return tagging; DRAM_ISSUE_STAT_EN adds issue/stall counters
module dram_cmd_issue_queue #(
  parameter int CMD_DEPTH = 8,
  parameter int TAG_DEPTH = 16,
  parameter int DATA_W    = 128,
  parameter int CMD_W     = 34
)(
  input  logic              clk,
  input  logic              power_on_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_command,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [7:0]        ba_cmd_pm,
  output logic [CMD_W-1:0]  command,
  output logic              valid,
  output logic [DATA_W-1:0] write_data,
  input  logic              read_data_valid,
  input  logic [DATA_W-1:0] read_data,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [27:0]       rdata_tag,
  output logic              rd_underflow
`ifdef DRAM_ISSUE_STAT_EN
  ,
  output logic [15:0]       stat_wr_cnt,
  output logic [15:0]       stat_rd_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int TAW = $clog2(TAG_DEPTH);
  localparam logic [CAW:0] C_ONE = 1;
  localparam logic [TAW:0] T_ONE = 1;
  logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
  logic [DATA_W-1:0] dat_mem [CMD_DEPTH];
  logic [27:0]       tag_mem [TAG_DEPTH];
  logic [CAW:0]      cwr, crd;
  logic [TAW:0]      twr, trd;
  logic              cmd_full, cmd_empty, tag_full, tag_empty;
  logic              push, issue, tag_push, tag_pop;
  logic [CMD_W-1:0]  head;
  logic [DATA_W-1:0] head_data;
  logic [27:0]       head_tag;
  // Extra pointer MSB distinguishes full from empty when the index bits match
  always_comb begin
    cmd_full  = (cwr[CAW] != crd[CAW]) && (cwr[CAW-1:0] == crd[CAW-1:0]);
    cmd_empty = cwr == crd;
    tag_full  = (twr[TAW] != trd[TAW]) && (twr[TAW-1:0] == trd[TAW-1:0]);
    tag_empty = twr == trd;
    in_ready  = !cmd_full;
    push      = in_valid && !cmd_full;
    head      = cmd_mem[crd[CAW-1:0]];
    head_data = dat_mem[crd[CAW-1:0]];
    head_tag  = {head[33:32], head[29:17], head[12:3], head[2:0]};
    issue     = !cmd_empty && ba_cmd_pm[head[2:0]] && (!head[31] || !tag_full);
    tag_push  = issue && head[31];
    tag_pop   = read_data_valid && !tag_empty;
  end
  // Storage arrays need no reset; pointers define which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[cwr[CAW-1:0]] <= in_command;
      dat_mem[cwr[CAW-1:0]] <= in_wdata;
    end
    if (tag_push) tag_mem[twr[TAW-1:0]] <= head_tag;
  end
  // Pointers and registered issue/return outputs; reset discards all queued work
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      cwr          <= '0;
      crd          <= '0;
      twr          <= '0;
      trd          <= '0;
      valid        <= 1'b0;
      command      <= '0;
      write_data   <= '0;
      rdata_valid  <= 1'b0;
      rdata        <= '0;
      rdata_tag    <= '0;
      rd_underflow <= 1'b0;
    end else begin
      if (push) cwr <= cwr + C_ONE;
      if (issue) crd <= crd + C_ONE;
      if (tag_push) twr <= twr + T_ONE;
      if (tag_pop) trd <= trd + T_ONE;
      valid        <= issue;
      command      <= issue ? head : '0;
      write_data   <= (issue && !head[31]) ? head_data : '0;
      rdata_valid  <= read_data_valid;
      rdata        <= read_data_valid ? read_data : '0;
      rdata_tag    <= tag_pop ? tag_mem[trd[TAW-1:0]] : '0;
      rd_underflow <= rd_underflow || (read_data_valid && tag_empty);
    end
  end
`ifdef DRAM_ISSUE_STAT_EN
  // Saturating issue and stall statistics
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      stat_wr_cnt    <= '0;
      stat_rd_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      stat_wr_cnt    <= stat_wr_cnt + 16'(issue && !head[31] && stat_wr_cnt != 16'hFFFF);
      stat_rd_cnt    <= stat_rd_cnt + 16'(tag_push && stat_rd_cnt != 16'hFFFF);
      stat_stall_cnt <= stat_stall_cnt + 16'(!cmd_empty && !issue && stat_stall_cnt != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_dram_cmd_issue_queue.sv
// tb_dram_cmd_issue_queue: scoreboard bench for the DRAM command issue queue
module tb_dram_cmd_issue_queue;
  localparam int DW = 128;
  logic clk = 1'b0, power_on_rst = 1'b1, in_valid = 1'b0, read_data_valid = 1'b0;
  logic [33:0] in_command = '0;
  logic [DW-1:0] in_wdata = '0, read_data = '0;
  logic [7:0] ba_cmd_pm = '0;
  logic in_ready, valid, rdata_valid, rd_underflow;
  logic [33:0] command;
  logic [DW-1:0] write_data, rdata;
  logic [27:0] rdata_tag;
  int checks = 0, errors = 0, cyc = 0, nvalid = 0, first_vcyc = -1, push_cyc, saved;
  logic [DW+33:0] exp_cmd [$];
  logic [27:0] exp_tag [$];
  logic [DW-1:0] exp_rd [$];
  logic [DW+33:0] mon_e;
  logic [27:0] mon_t;
  logic [DW-1:0] mon_d;

  dram_cmd_issue_queue dut (
    .clk(clk), .power_on_rst(power_on_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_wdata(in_wdata), .ba_cmd_pm(ba_cmd_pm),
    .command(command), .valid(valid), .write_data(write_data),
    .read_data_valid(read_data_valid), .read_data(read_data),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_tag(rdata_tag), .rd_underflow(rd_underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mkcmd(input logic rw, input logic [1:0] rank, input logic [2:0] bank,
                                        input logic [12:0] row, input logic [9:0] col);
    return {rank, rw, 1'b0, row, 4'b0, col, bank};
  endfunction

  function automatic logic [27:0] tag_of(input logic [33:0] c);
    return {c[33:32], c[29:17], c[12:3], c[2:0]};
  endfunction

  task automatic push(input logic [33:0] c, input logic [DW-1:0] d);
    int n = 0;
    in_valid = 1'b1; in_command = c; in_wdata = d;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("push_accept", in_ready, 1);
    exp_cmd.push_back({c, c[31] ? {DW{1'b0}} : d});
    if (c[31]) exp_tag.push_back(tag_of(c));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic ret(input logic [DW-1:0] d);
    read_data_valid = 1'b1; read_data = d;
    exp_rd.push_back(d);
    @(posedge clk); #1;
    read_data_valid = 1'b0;
  endtask

  task automatic wait_n(input int target);
    for (int i = 0; i < 100 && nvalid < target; i++) @(posedge clk);
    #1;
    chk("issued_count", nvalid, target);
  endtask

  // Scoreboard: compare every issued command and every tagged return in order
  always @(negedge clk) begin
    if (valid) begin
      nvalid++;
      if (first_vcyc < 0) first_vcyc = cyc;
      if (exp_cmd.size() == 0) chk("unexpected_valid", command, 0);
      else begin
        mon_e = exp_cmd.pop_front();
        chk("command", command, mon_e[DW+33:DW]);
        chk("write_data", write_data, mon_e[DW-1:0]);
      end
    end
    if (rdata_valid) begin
      mon_t = exp_tag.size() ? exp_tag.pop_front() : 28'd0;
      mon_d = exp_rd.size() ? exp_rd.pop_front() : {DW{1'bx}};
      chk("rdata", rdata, mon_d);
      chk("rdata_tag", rdata_tag, mon_t);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    power_on_rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_command", command, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata_tag", rdata_tag, 0);
    chk("rst_underflow", rd_underflow, 0);
    ba_cmd_pm = 8'hFF;
    push_cyc = cyc;
    for (int i = 0; i < 4; i++) push(mkcmd(1'b0, 2'd0, 3'(i), 13'd0, 10'd0), DW'(128'hA0 + i));
    wait_n(4);
    chk("first_latency", first_vcyc - push_cyc, 2);
    ba_cmd_pm = 8'hFB;
    push(mkcmd(1'b0, 2'd1, 3'd2, 13'd7, 10'd3), DW'(128'hB2));
    push(mkcmd(1'b0, 2'd1, 3'd3, 13'd7, 10'd3), DW'(128'hB3));
    repeat (5) @(posedge clk);
    #1;
    chk("hol_blocked", nvalid, 4);
    ba_cmd_pm = 8'hFF;
    @(negedge clk); chk("hol_t0_valid", valid, 0);
    @(negedge clk); chk("hol_t1_valid", valid, 1); chk("hol_t1_bank", command[2:0], 2);
    @(negedge clk); chk("hol_t2_valid", valid, 1); chk("hol_t2_bank", command[2:0], 3);
    @(posedge clk); #1;
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 8; i++) push(mkcmd(1'b0, 2'd2, 3'(i), 13'(i), 10'(i)), DW'(128'hC0 + i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_command = mkcmd(1'b0, 2'd3, 3'd0, 13'd0, 10'd0); in_wdata = DW'(128'hDEAD);
    @(posedge clk); #1;
    in_valid = 1'b0;
    ba_cmd_pm = 8'hFF;
    wait_n(14);
    chk("drained_in_ready", in_ready, 1);
    push(mkcmd(1'b1, 2'd0, 3'd1, 13'd5, 10'd8), '0);
    push(mkcmd(1'b1, 2'd0, 3'd3, 13'd15, 10'd56), '0);
    wait_n(16);
    ret(DW'(128'h1111));
    ret(DW'(128'h2222));
    repeat (3) @(posedge clk);
    #1;
    chk("tags_no_underflow", rd_underflow, 0);
    for (int i = 0; i < 17; i++) push(mkcmd(1'b1, 2'd1, 3'(i % 8), 13'(i), 10'(i)), '0);
    repeat (10) @(posedge clk);
    #1;
    chk("tagfull_issued", nvalid, 32);
    ret(DW'(128'h3000));
    @(negedge clk); chk("tagfull_pop_cycle", valid, 0);
    @(negedge clk); chk("tagfull_17th_issue", valid, 1);
    for (int i = 1; i < 17; i++) ret(DW'(128'h3000 + i));
    repeat (3) @(posedge clk);
    #1;
    chk("all_tags_returned", exp_tag.size(), 0);
    chk("drain_no_underflow", rd_underflow, 0);
    ret(DW'(128'h4444));
    chk("underflow_set", rd_underflow, 1);
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 3; i++) push(mkcmd(1'b0, 2'd0, 3'(i), 13'd1, 10'd1), DW'(128'hE0 + i));
    saved = nvalid;
    #2;
    power_on_rst = 1'b1;
    #1;
    chk("mid_rst_underflow", rd_underflow, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_command", command, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_cmd.delete();
    exp_tag.delete();
    exp_rd.delete();
    @(posedge clk); #1;
    power_on_rst = 1'b0;
    ba_cmd_pm = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    chk("no_reissue", nvalid, saved);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
